// File: rtl/kernel_stream_writer.sv
// Kernel store write side: packs a valid/ready byte stream into 3x3 kernel words held in a
// register bank, with a combinational per-channel read port for the kernel-latching logic.
module kernel_stream_writer #(
  parameter int unsigned NUM_KERNELS = 8,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic signed [7:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              loaded,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic signed [7:0] k0,
  output logic signed [7:0] k1,
  output logic signed [7:0] k2,
  output logic signed [7:0] k3,
  output logic signed [7:0] k4,
  output logic signed [7:0] k5,
  output logic signed [7:0] k6,
  output logic signed [7:0] k7,
  output logic signed [7:0] k8
);

  localparam int unsigned KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam logic [ADDR_W-1:0] LastKidx = ADDR_W'(NUM_KERNELS - 1);
  localparam logic [ADDR_W:0]   NumKernels = (ADDR_W + 1)'(NUM_KERNELS);
  localparam logic [3:0]        LastTap = 4'd8;

  typedef enum logic [1:0] {StIdle, StLoad, StCommit, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        tap_cnt_q, tap_cnt_d;
  logic [ADDR_W-1:0] kidx_q, kidx_d;
  logic              loaded_q, loaded_d;
  logic [7:0]        taps_q [9];
  logic [71:0]       bank_q [NUM_KERNELS];
  logic [71:0]       word_packed;
  logic [71:0]       rd_word;
  logic              beat;

  assign beat = (state_q == StLoad) && s_valid;

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    kidx_d    = kidx_q;
    loaded_d  = loaded_q;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          tap_cnt_d = '0;
          kidx_d    = '0;
          loaded_d  = 1'b0;
        end
      end
      StLoad: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (tap_cnt_q == LastTap) begin
            state_d   = StCommit;
            tap_cnt_d = '0;
          end else begin
            tap_cnt_d = tap_cnt_q + 4'd1;
          end
        end
      end
      StCommit: begin
        busy = 1'b1;
        if (kidx_q == LastKidx) begin
          state_d = StDone;
        end else begin
          kidx_d  = kidx_q + 1'b1;
          state_d = StLoad;
        end
      end
      StDone: begin
        done     = 1'b1;
        loaded_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      tap_cnt_q <= '0;
      kidx_q    <= '0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      kidx_q    <= kidx_d;
      loaded_q  <= loaded_d;
    end
  end

  // Staging taps; a reset drops any partial group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        taps_q[i] <= '0;
      end
    end else if (beat) begin
      taps_q[tap_cnt_q] <= s_data;
    end
  end

  always_comb begin
    word_packed = '0;
    for (int i = 0; i < 9; i++) begin
      word_packed[8*i +: 8] = taps_q[i];
    end
  end

  // The bank entry changes on the edge that ends COMMIT, so readers see old taps until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_KERNELS); i++) begin
        bank_q[i] <= '0;
      end
    end else if (state_q == StCommit) begin
      bank_q[kidx_q[KW-1:0]] <= word_packed;
    end
  end

  always_comb begin
    rd_word = '0;
    if ({1'b0, rd_addr} < NumKernels) begin
      rd_word = bank_q[rd_addr[KW-1:0]];
    end
  end

  assign k0     = rd_word[7:0];
  assign k1     = rd_word[15:8];
  assign k2     = rd_word[23:16];
  assign k3     = rd_word[31:24];
  assign k4     = rd_word[39:32];
  assign k5     = rd_word[47:40];
  assign k6     = rd_word[55:48];
  assign k7     = rd_word[63:56];
  assign k8     = rd_word[71:64];
  assign loaded = loaded_q;

endmodule
